buffer3: RTL and testbench
==========================

Name: buffer3

Overview:
- Execute-to-writeback pipeline register with a valid/ready handshake on both sides.
- Input side takes the ALU result and side data produced from the ID/EX register outputs (aluIn1, aluIn2, op1Datas3, instructions3, control bits).
- Output side presents one registered entry per cycle to the memory/writeback stage.
- Two-entry skid storage lets downstream back-pressure stall execute without losing data; flush discards in-flight entries on a branch or exception.

Parameters:
- DW, 16, width of the data fields (aluResult, op1Data, instruction).
- CW, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- aluResults3  in  DW  ALU result from execute.
- op1Datas3  in  DW  store/forward data carried from the ID/EX register.
- instructions3  in  DW  instruction word.
- r0Writes3, regWrites3, wEnables3  in  1 each  write-back and memory control.
- inValid  in  1  execute presents a valid entry.
- inReady  out  1  buffer can accept an entry this cycle.
- flush  in  1  synchronous discard of all held entries.
- aluResults4, op1Datas4, instructions4  out  DW  head entry data.
- r0Writes4, regWrites4, wEnables4  out  1  head entry controls.
- outValid  out  1  head entry is valid.
- outReady  in  1  downstream consumes the head this cycle.
- stallCount  out  CW  cycles with outValid=1 and outReady=0.

Behaviour:
- Storage:
  - Head register: payload plus headValid.
  - Skid register: payload plus skidValid.
  - outValid = headValid; all data/control outputs come straight from head flops, no combinational input-to-output path.
- inReady = !skidValid. Registered, never derived from outReady.
- Events: accept = inValid & inReady; pop = headValid & outReady.
- Per-cycle update, no flush:
  - Head is free when !headValid or pop.
  - Head free and skidValid: head <= skid, skidValid <= 0. If accept also occurs, the input goes to head's vacated slot in skid (skid <= input, skidValid <= 1).
  - Head free and !skidValid: head <= input, headValid <= accept.
  - Head not free and accept: skid <= input, skidValid <= 1.
- Ordering: strictly FIFO; the skid entry always reaches head before any newer entry.
- Latency: accept in cycle N → outValid in cycle N+1. Sustained throughput is 1 entry/cycle while outReady=1.
- Full: headValid & skidValid → inReady=0 in that cycle; inValid is ignored.
- Flush:
  - Next edge clears headValid and skidValid; payload flops may keep stale values.
  - Flush beats a simultaneous accept (input dropped) and a simultaneous pop. The downstream still sees the pop-cycle head as consumed, since it sampled it.
  - inReady=1 in the cycle after a flush.
- stallCount:
  - Increments when outValid & !outReady; saturates at all-ones.
  - Cleared only by reset; unaffected by flush.
- Reset (rst_n=0, asynchronous):
  - headValid=0, skidValid=0, every payload output 0, stallCount=0.
  - inReady=1 while in reset and after release.
  - Reset mid-transfer discards all entries; the first edge after release behaves as empty.
- Control bits of an invalid head are don't-care to the consumer, but must hold their last value (no X).

Decomposition:
- Shared package holds:
  - DW default 16.
  - Payload-field widths and bit offsets for the packed entry {aluResult, op1Data, instruction, r0Write, regWrite, wEnable} = 51 bits.
- One sub-module is natural: pipe_entry_reg, a loadable register of the packed payload with a valid bit and async reset. Instantiate it twice (head, skid).
- Handshake and counter logic stay in buffer3.

Test Plan:
- Reset then single entry: assert rst_n=0 for 3 cycles, release. Drive aluResults3=16'h1234, instructions3=16'hA005, regWrites3=1, inValid=1 for one cycle with outReady=1 → outValid=1 next cycle, aluResults4=16'h1234, instructions4=16'hA005, regWrites4=1; outValid=0 the cycle after.
- Back-pressure: outReady=0, stream entries 1,2,3 → 1 in head, 2 in skid, inReady=0 while 3 is held by the source. Raise outReady → outputs 1,2,3 on consecutive cycles; stallCount equals the number of held cycles.
- Full throughput: outReady=1, inValid=1 for 8 cycles with aluResult=0..7 → outputs 0..7 on cycles 1..8, inReady stays 1, stallCount=0.
- Flush with full buffer: head=5, skid=6, flush=1 together with inValid=1 (data 7) → next cycle outValid=0, inReady=1; entry 7 never appears.
- Async reset mid-stall: headValid=skidValid=1, drop rst_n between clock edges → outputs immediately 0, outValid=0, stallCount=0 without a clock edge.
- Saturation (CW overridden to 4): hold outValid=1, outReady=0 for 20 cycles → stallCount stops at 4'hF.

Source files
------------

// File: rtl/buffer3_pkg.sv
// Shared definitions for the EX->WB pipeline buffer: default widths and the
// packed entry layout {aluResult, op1Data, instruction, r0Write, regWrite, wEnable}.
package buffer3_pkg;

  localparam int unsigned DW_DEFAULT = 16;
  localparam int unsigned CW_DEFAULT = 16;

  // Control bits occupy the low end of the packed entry, data fields above them.
  localparam int unsigned CTRL_W = 3;
  localparam int unsigned WE_BIT = 0;
  localparam int unsigned RW_BIT = 1;
  localparam int unsigned R0_BIT = 2;

  function automatic int unsigned entry_width(input int unsigned dw);
    return 3 * dw + CTRL_W;
  endfunction

endpackage

// File: rtl/buffer3_if.sv
// Handshake bundle between execute, the EX->WB buffer and the writeback stage.
interface buffer3_if #(
  parameter int unsigned DW = 16
);
  logic [DW-1:0] aluResults3;
  logic [DW-1:0] op1Datas3;
  logic [DW-1:0] instructions3;
  logic          r0Writes3;
  logic          regWrites3;
  logic          wEnables3;
  logic          inValid;
  logic          inReady;
  logic          flush;

  logic [DW-1:0] aluResults4;
  logic [DW-1:0] op1Datas4;
  logic [DW-1:0] instructions4;
  logic          r0Writes4;
  logic          regWrites4;
  logic          wEnables4;
  logic          outValid;
  logic          outReady;

  modport slave (
    input  aluResults3, op1Datas3, instructions3, r0Writes3, regWrites3, wEnables3,
    input  inValid, flush, outReady,
    output inReady,
    output aluResults4, op1Datas4, instructions4, r0Writes4, regWrites4, wEnables4,
    output outValid
  );

  modport master (
    output aluResults3, op1Datas3, instructions3, r0Writes3, regWrites3, wEnables3,
    output inValid, flush, outReady,
    input  inReady,
    input  aluResults4, op1Datas4, instructions4, r0Writes4, regWrites4, wEnables4,
    input  outValid
  );

endinterface

// File: rtl/buffer3_pipe_entry_reg.sv
// Loadable payload register with its own valid flop; payload changes only on load.
module pipe_entry_reg #(
  parameter int unsigned W = 51
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         valid_d,
  output logic [W-1:0] q,
  output logic         valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      valid <= 1'b0;
    end else begin
      valid <= valid_d;
      if (load) q <= d;
    end
  end

endmodule

// File: rtl/buffer3.sv
// EX->WB pipeline buffer: head register plus one skid slot, FIFO ordered,
// registered ready, synchronous flush and a saturating back-pressure counter.
module buffer3
  import buffer3_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  buffer3_if.slave      bus,
  output logic [CW-1:0] stallCount
);

  localparam int unsigned EW = entry_width(DW);

  logic [EW-1:0] in_entry;
  logic [EW-1:0] head_d;
  logic [EW-1:0] head_q;
  logic [EW-1:0] skid_q;
  logic          head_valid;
  logic          skid_valid;
  logic          head_load;
  logic          skid_load;
  logic          head_valid_d;
  logic          skid_valid_d;
  logic          accept;
  logic          pop;
  logic          head_free;

  assign in_entry  = {bus.aluResults3, bus.op1Datas3, bus.instructions3,
                      bus.r0Writes3, bus.regWrites3, bus.wEnables3};
  assign bus.inReady = !skid_valid;
  assign accept    = bus.inValid & !skid_valid;
  assign pop       = head_valid & bus.outReady;
  assign head_free = !head_valid | pop;
  assign head_d    = skid_valid ? skid_q : in_entry;

  // Head loads only on a real transfer so an idle head keeps its last payload.
  always_comb begin
    head_load    = 1'b0;
    skid_load    = 1'b0;
    head_valid_d = head_valid;
    skid_valid_d = skid_valid;
    if (bus.flush) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (head_free) begin
      if (skid_valid) begin
        head_load    = 1'b1;
        head_valid_d = 1'b1;
        skid_load    = accept;
        skid_valid_d = accept;
      end else begin
        head_load    = accept;
        head_valid_d = accept;
      end
    end else if (accept) begin
      skid_load    = 1'b1;
      skid_valid_d = 1'b1;
    end
  end

  pipe_entry_reg #(.W(EW)) u_head (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (head_load),
    .d       (head_d),
    .valid_d (head_valid_d),
    .q       (head_q),
    .valid   (head_valid)
  );

  pipe_entry_reg #(.W(EW)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_load),
    .d       (in_entry),
    .valid_d (skid_valid_d),
    .q       (skid_q),
    .valid   (skid_valid)
  );

  assign bus.outValid      = head_valid;
  assign bus.wEnables4     = head_q[WE_BIT];
  assign bus.regWrites4    = head_q[RW_BIT];
  assign bus.r0Writes4     = head_q[R0_BIT];
  assign bus.instructions4 = head_q[CTRL_W +: DW];
  assign bus.op1Datas4     = head_q[CTRL_W + DW +: DW];
  assign bus.aluResults4   = head_q[CTRL_W + 2 * DW +: DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCount <= '0;
    end else if (head_valid && !bus.outReady && stallCount != '1) begin
      stallCount <= stallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_buffer3.sv
// Self-checking bench for buffer3: directed scenarios plus randomized traffic
// compared against a two-deep FIFO reference model.
module tb_buffer3;

  typedef struct packed {
    logic [15:0] alu;
    logic [15:0] op1;
    logic [15:0] ins;
    logic        r0;
    logic        rw;
    logic        we;
  } tb_entry_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_s_n = 1'b0;
  always #5 clk = ~clk;

  buffer3_if #(.DW(16)) bus ();
  buffer3_if #(.DW(16)) bus_s ();
  logic [15:0] stall;
  logic [3:0]  stall_s;

  buffer3 #(.DW(16), .CW(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .stallCount (stall)
  );

  buffer3 #(.DW(16), .CW(4)) dut_s (
    .clk        (clk),
    .rst_n      (rst_s_n),
    .bus        (bus_s.slave),
    .stallCount (stall_s)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  tb_entry_t   model[$];
  logic [15:0] exp_stall;

  function automatic tb_entry_t cur_in();
    return {bus.aluResults3, bus.op1Datas3, bus.instructions3,
            bus.r0Writes3, bus.regWrites3, bus.wEnables3};
  endfunction

  function automatic tb_entry_t cur_out();
    return {bus.aluResults4, bus.op1Datas4, bus.instructions4,
            bus.r0Writes4, bus.regWrites4, bus.wEnables4};
  endfunction

  task automatic drive_idle();
    bus.aluResults3 = '0; bus.op1Datas3 = '0; bus.instructions3 = '0;
    bus.r0Writes3 = 0; bus.regWrites3 = 0; bus.wEnables3 = 0;
    bus.inValid = 0; bus.flush = 0; bus.outReady = 0;
  endtask

  task automatic drive_data(input logic [15:0] alu);
    bus.aluResults3 = alu;
    bus.op1Datas3 = 16'($urandom);
    bus.instructions3 = 16'($urandom);
    bus.r0Writes3 = 1'($urandom);
    bus.regWrites3 = 1'($urandom);
    bus.wEnables3 = 1'($urandom);
  endtask

  // One clock: reference model sees the pre-edge inputs, then outputs settle.
  task automatic tick();
    bit acc, pp;
    acc = bus.inValid && (model.size() < 2);
    pp  = (model.size() > 0) && bus.outReady;
    if (model.size() > 0 && !bus.outReady && exp_stall != 16'hFFFF) exp_stall++;
    @(posedge clk);
    if (bus.flush) model.delete();
    else begin
      if (pp) void'(model.pop_front());
      if (acc) model.push_back(cur_in());
    end
    #1;
  endtask

  task automatic apply_reset();
    drive_idle();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    model.delete();
    exp_stall = '0;
    rst_n = 1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.outValid !== 1'b0 || bus.inReady !== 1'b1 || stall !== 16'h0 || cur_out() !== '0) begin
      errors++;
      $display("FAIL reset: outValid=%b inReady=%b stall=%h out=%h, required 0/1/0/0",
               bus.outValid, bus.inReady, stall, cur_out());
    end
    model.delete();
    exp_stall = '0;
    rst_n = 1;
  endtask

  task automatic test_single();
    drive_idle();
    bus.aluResults3 = 16'h1234; bus.instructions3 = 16'hA005; bus.regWrites3 = 1;
    bus.inValid = 1; bus.outReady = 1;
    tick();
    bus.inValid = 0;
    checks++;
    if (bus.outValid !== 1'b1 || bus.aluResults4 !== 16'h1234 ||
        bus.instructions4 !== 16'hA005 || bus.regWrites4 !== 1'b1) begin
      errors++;
      $display("FAIL single_out: v=%b alu=%h ins=%h rw=%b, required 1/1234/a005/1",
               bus.outValid, bus.aluResults4, bus.instructions4, bus.regWrites4);
    end
    tick();
    checks++;
    if (bus.outValid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: outValid=%b, required 0", bus.outValid);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    bus.outReady = 0;
    bus.inValid = 1;
    for (int unsigned i = 1; i <= 3; i++) begin
      drive_data(16'(i));
      tick();
    end
    tick();
    checks++;
    if (bus.inReady !== 1'b0 || bus.aluResults4 !== 16'd1 || bus.outValid !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: inReady=%b alu=%h v=%b, required 0/0001/1",
               bus.inReady, bus.aluResults4, bus.outValid);
    end
    bus.outReady = 1;
    for (int unsigned k = 2; k <= 3; k++) begin
      tick();
      checks++;
      if (bus.outValid !== 1'b1 || bus.aluResults4 !== 16'(k) || cur_out() !== model[0]) begin
        errors++;
        $display("FAIL bp_drain: v=%b alu=%h, required 1/%h", bus.outValid, bus.aluResults4, 16'(k));
      end
      if (k == 2) bus.inValid = 1;
      else bus.inValid = 0;
    end
    tick();
    checks++;
    if (bus.outValid !== 1'b0 || stall !== 16'd3) begin
      errors++;
      $display("FAIL bp_stall: v=%b stall=%0d, required 0/3", bus.outValid, stall);
    end
  endtask

  task automatic test_throughput();
    apply_reset();
    bus.outReady = 1;
    bus.inValid = 1;
    for (int unsigned i = 0; i < 8; i++) begin
      drive_data(16'(i));
      tick();
      checks++;
      if (bus.outValid !== 1'b1 || bus.aluResults4 !== 16'(i) || bus.inReady !== 1'b1) begin
        errors++;
        $display("FAIL thru_%0d: v=%b alu=%h rdy=%b, required 1/%h/1",
                 i, bus.outValid, bus.aluResults4, bus.inReady, 16'(i));
      end
    end
    bus.inValid = 0;
    checks++;
    if (stall !== 16'd0) begin
      errors++;
      $display("FAIL thru_stall: stall=%0d, required 0", stall);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    bus.outReady = 0;
    bus.inValid = 1;
    drive_data(16'd5); tick();
    drive_data(16'd6); tick();
    bus.flush = 1;
    drive_data(16'd7);
    tick();
    bus.flush = 0;
    bus.inValid = 0;
    checks++;
    if (bus.outValid !== 1'b0 || bus.inReady !== 1'b1) begin
      errors++;
      $display("FAIL flush_clear: v=%b rdy=%b, required 0/1", bus.outValid, bus.inReady);
    end
    bus.outReady = 1;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.outValid !== 1'b0) begin
        errors++;
        $display("FAIL flush_ghost: v=%b alu=%h, required 0", bus.outValid, bus.aluResults4);
      end
    end
    checks++;
    if (stall !== 16'd2 || stall !== exp_stall) begin
      errors++;
      $display("FAIL flush_stall: stall=%0d, required 2", stall);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int unsigned c = 0; c < 400; c++) begin
      drive_data(16'($urandom));
      bus.inValid  = ($urandom_range(0, 3) != 0);
      bus.outReady = ($urandom_range(0, 2) != 0);
      bus.flush    = ($urandom_range(0, 19) == 0);
      tick();
      checks++;
      if (bus.inReady !== (model.size() < 2) || stall !== exp_stall ||
          bus.outValid !== (model.size() > 0) ||
          (model.size() > 0 && cur_out() !== model[0])) begin
        errors++;
        $display("FAIL random_%0d: v=%b rdy=%b out=%h stall=%0d, required v=%0d rdy=%0d head=%h stall=%0d",
                 c, bus.outValid, bus.inReady, cur_out(), stall, model.size() > 0,
                 model.size() < 2, (model.size() > 0) ? model[0] : tb_entry_t'('0), exp_stall);
      end
    end
    drive_idle();
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus.outReady = 0;
    bus.inValid = 1;
    drive_data(16'hBEEF); tick();
    drive_data(16'hCAFE); tick();
    bus.inValid = 0;
    tick();
    #2 rst_n = 0;
    #1;
    checks++;
    if (bus.outValid !== 1'b0 || cur_out() !== '0 || stall !== 16'h0 || bus.inReady !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: v=%b out=%h stall=%0d rdy=%b, required 0/0/0/1",
               bus.outValid, cur_out(), stall, bus.inReady);
    end
    model.delete();
    exp_stall = '0;
    @(posedge clk);
    #1 rst_n = 1;
    bus.outReady = 1;
    bus.inValid = 1;
    drive_data(16'h0042);
    tick();
    bus.inValid = 0;
    checks++;
    if (bus.outValid !== 1'b1 || bus.aluResults4 !== 16'h0042 || cur_out() !== model[0]) begin
      errors++;
      $display("FAIL async_restart: v=%b alu=%h, required 1/0042", bus.outValid, bus.aluResults4);
    end
  endtask

  task automatic test_saturation();
    int unsigned held;
    bus_s.aluResults3 = 16'h0055; bus_s.op1Datas3 = '0; bus_s.instructions3 = '0;
    bus_s.r0Writes3 = 0; bus_s.regWrites3 = 0; bus_s.wEnables3 = 0;
    bus_s.flush = 0; bus_s.outReady = 0; bus_s.inValid = 1;
    rst_s_n = 1;
    @(posedge clk); #1;
    bus_s.inValid = 0;
    held = 0;
    for (int unsigned i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      held++;
      checks++;
      if (stall_s !== 4'((held > 15) ? 15 : held) || bus_s.outValid !== 1'b1) begin
        errors++;
        $display("FAIL saturate_%0d: stall=%h v=%b, required %h/1",
                 i, stall_s, bus_s.outValid, 4'((held > 15) ? 15 : held));
      end
    end
  endtask

  initial begin
    drive_idle();
    bus_s.aluResults3 = '0; bus_s.op1Datas3 = '0; bus_s.instructions3 = '0;
    bus_s.r0Writes3 = 0; bus_s.regWrites3 = 0; bus_s.wEnables3 = 0;
    bus_s.inValid = 0; bus_s.flush = 0; bus_s.outReady = 0;
    exp_stall = '0;
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_throughput();
    test_flush();
    test_random();
    test_async_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
